apb_master: RTL
===============

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, giving the maximum ACCESS cycles with P_ready low before abort (0 disables the timeout, range 0-255).
REQ-002 SHALL have port P_clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port P_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-005 SHALL have port cmd_ready, output, 1 bit: a command can be accepted this cycle.
REQ-006 SHALL have port cmd_write, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port cmd_addr, input, 32 bits: transfer address.
REQ-008 SHALL have port cmd_wdata, input, 32 bits: write data.
REQ-009 SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata, output, 32 bits: read data.
REQ-011 SHALL have port rsp_slverr, output, 1 bit: error flag, set for a slave error or a timeout.
REQ-012 SHALL have port rsp_timeout, output, 1 bit: the transfer was aborted by the timeout.
REQ-013 SHALL have port P_addr, output, 32 bits: APB address.
REQ-014 SHALL have port P_selx, output, 1 bit: APB select.
REQ-015 SHALL have port P_enable, output, 1 bit: APB enable.
REQ-016 SHALL have port P_write, output, 1 bit: APB direction.
REQ-017 SHALL have port P_wdata, output, 32 bits: APB write data.
REQ-018 SHALL have port P_ready, input, 1 bit: slave ready.
REQ-019 SHALL have port P_slverr, input, 1 bit: slave error.
REQ-020 SHALL have port P_rdata, input, 32 bits: slave read data.

Function
REQ-021 SHALL implement a registered FSM with states IDLE=2'b00, SETUP=2'b01 and ACCESS=2'b10; unused encodings SHALL return to IDLE.
REQ-022 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on the edge where cmd_valid and cmd_ready are both 1, and the FSM then moves IDLE->SETUP.
REQ-023 SHALL register cmd_addr, cmd_wdata and cmd_write into P_addr, P_wdata and P_write on acceptance, holding them stable through SETUP and ACCESS and holding the last values while IDLE.
REQ-024 SHALL drive P_selx=1 and P_enable=0 in SETUP, P_selx=1 and P_enable=1 in ACCESS, and both 0 in IDLE.
REQ-025 SHALL move SETUP->ACCESS unconditionally after exactly one cycle.
REQ-026 SHALL move ACCESS->IDLE on the edge where P_ready=1, and otherwise remain in ACCESS (wait state) while incrementing an 8-bit wait counter that clears on entry to SETUP.
REQ-027 SHALL, when TIMEOUT!=0 and the wait counter equals TIMEOUT with P_ready=0, move ACCESS->IDLE and abort the transfer.
REQ-028 SHALL assert rsp_valid for exactly one cycle, the cycle following the ACCESS->IDLE edge.
REQ-029 SHALL, on a normal completion, capture rsp_slverr=P_slverr and rsp_timeout=0, and set rsp_rdata=P_rdata for a read or 32'h0 for a write.
REQ-030 SHALL, on a timeout abort, set rsp_slverr=1, rsp_timeout=1 and rsp_rdata=32'h0.
REQ-031 SHALL keep rsp_rdata, rsp_slverr and rsp_timeout stable until the next rsp_valid pulse.
REQ-032 SHALL allow back-to-back transfers: a command accepted during the IDLE cycle carrying rsp_valid enters SETUP on the next edge, so the minimum transfer period is 3 cycles.
REQ-033 SHALL ignore cmd_valid outside IDLE and SHALL NOT change P_addr, P_wdata or P_write mid-transfer.
REQ-034 SHALL ignore P_ready and P_slverr outside ACCESS.

Reset
REQ-035 SHALL, while P_rst_n=0, immediately force state=IDLE, P_selx=0, P_enable=0, P_write=0, P_addr=0, P_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_slverr=0, rsp_timeout=0, wait counter=0 and cmd_ready=0.
REQ-036 SHALL abandon any in-flight transfer when reset is asserted and SHALL generate no rsp_valid for it; cmd_ready=1 from the first cycle after P_rst_n rises.

Verification
REQ-037 SHALL pass this scenario: write addr=0x04, data=0xDEADBEEF, P_ready=1 in the first ACCESS cycle -> SETUP for 1 cycle, ACCESS for 1 cycle, then rsp_valid=1 with rsp_slverr=0 and rsp_rdata=0.
REQ-038 SHALL pass this scenario: read addr=0x08, P_ready low for 2 ACCESS cycles then high with P_rdata=0x12345678 -> 3 ACCESS cycles, then rsp_rdata=0x12345678 and P_addr held at 0x08 throughout.
REQ-039 SHALL pass this scenario: P_ready=1 with P_slverr=1 on a write -> rsp_valid=1, rsp_slverr=1, rsp_timeout=0.
REQ-040 SHALL pass this scenario: TIMEOUT=4 with P_ready held at 0 -> the transfer aborts after 5 ACCESS cycles (wait counter 0-4), then rsp_slverr=1, rsp_timeout=1 and P_selx=0.
REQ-041 SHALL pass this scenario: cmd_valid held high with two queued commands -> the second SETUP begins in the cycle directly after the first rsp_valid cycle, giving a 3-cycle period.
REQ-042 SHALL pass this scenario: P_rst_n driven low during ACCESS -> P_selx and P_enable go to 0 without waiting for a clock edge, no rsp_valid is produced, and after release a new command completes normally.

Source files
------------

// File: rtl/apb_master.sv
// APB master: turns a valid/ready command into one APB SETUP/ACCESS transfer.
// Returns a one-cycle response pulse with read data, slave error and timeout status.
module apb_master #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        P_clk,
   input  logic        P_rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_slverr,
   output logic        rsp_timeout,
   output logic [31:0] P_addr,
   output logic        P_selx,
   output logic        P_enable,
   output logic        P_write,
   output logic [31:0] P_wdata,
   input  logic        P_ready,
   input  logic        P_slverr,
   input  logic [31:0] P_rdata
);

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StSetup  = 2'b01,
      StAccess = 2'b10
   } state_e;

   localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

   state_e     state_q, state_d;
   logic [7:0] wait_q, wait_d;
   logic       accept;
   logic       done;
   logic       abort;
   logic       timeout_hit;

   // Reset gating keeps cmd_ready low while the block is held in reset.
   assign cmd_ready   = (state_q == StIdle) && P_rst_n;
   assign accept      = cmd_valid && cmd_ready;
   assign timeout_hit = (TIMEOUT != 0) && (wait_q == TimeoutVal);

   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      done     = 1'b0;
      abort    = 1'b0;
      P_selx   = 1'b0;
      P_enable = 1'b0;
      case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StSetup;
               wait_d  = '0;
            end
         end
         StSetup: begin
            P_selx  = 1'b1;
            state_d = StAccess;
         end
         StAccess: begin
            P_selx   = 1'b1;
            P_enable = 1'b1;
            if (P_ready) begin
               done    = 1'b1;
               state_d = StIdle;
            end else if (timeout_hit) begin
               abort   = 1'b1;
               state_d = StIdle;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge P_clk or negedge P_rst_n) begin
      if (!P_rst_n) begin
         state_q <= StIdle;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // Transfer attributes are only loaded on acceptance, so they hold through the transfer.
   always_ff @(posedge P_clk or negedge P_rst_n) begin
      if (!P_rst_n) begin
         P_addr  <= '0;
         P_wdata <= '0;
         P_write <= 1'b0;
      end else if (accept) begin
         P_addr  <= cmd_addr;
         P_wdata <= cmd_wdata;
         P_write <= cmd_write;
      end
   end

   always_ff @(posedge P_clk or negedge P_rst_n) begin
      if (!P_rst_n) begin
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_slverr  <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         rsp_valid <= done || abort;
         if (done) begin
            rsp_rdata   <= P_write ? 32'h0 : P_rdata;
            rsp_slverr  <= P_slverr;
            rsp_timeout <= 1'b0;
         end else if (abort) begin
            rsp_rdata   <= 32'h0;
            rsp_slverr  <= 1'b1;
            rsp_timeout <= 1'b1;
         end
      end
   end

endmodule
